// File: rtl/y86_pkg.sv
// Shared definitions for the sequential stage controller: instruction codes,
// status codes, controller states and small opcode-class helpers.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'd0;
  localparam logic [3:0] I_NOP    = 4'd1;
  localparam logic [3:0] I_RRMOVQ = 4'd2;
  localparam logic [3:0] I_IRMOVQ = 4'd3;
  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPDATE  = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  // Instructions that touch data memory.
  function automatic logic is_mem_op(input logic [3:0] ic);
    return (ic == I_RMMOVQ) || (ic == I_MRMOVQ) || (ic == I_CALL) ||
           (ic == I_RET)    || (ic == I_PUSHQ)  || (ic == I_POPQ);
  endfunction

  // Memory instructions that store rather than load.
  function automatic logic is_mem_write(input logic [3:0] ic);
    return (ic == I_RMMOVQ) || (ic == I_CALL) || (ic == I_PUSHQ);
  endfunction

  // valE writeback; conditional moves only commit when the condition held.
  function automatic logic writes_vale(input logic [3:0] ic, input logic c);
    return (ic == I_IRMOVQ) || (ic == I_OPQ)   || (ic == I_CALL) ||
           (ic == I_RET)    || (ic == I_PUSHQ) || (ic == I_POPQ) ||
           ((ic == I_RRMOVQ) && c);
  endfunction

  // valM writeback: loads from memory.
  function automatic logic writes_valm(input logic [3:0] ic);
    return (ic == I_MRMOVQ) || (ic == I_POPQ);
  endfunction

endpackage

// File: rtl/seq_stage_ctrl_if.sv
// Handshake and status bundle between the stage controller and its datapath.
interface seq_stage_ctrl_if;
  logic        start;
  logic        instr_valid;
  logic [3:0]  icode;
  logic        imem_error;
  logic        cnd;
  logic        dmem_ack;
  logic        dmem_error;
  logic        fetch_en;
  logic        decode_en;
  logic        execute_en;
  logic        memory_en;
  logic        wb_en;
  logic        pc_en;
  logic        dmem_req;
  logic        dmem_write;
  logic        rf_we_e;
  logic        rf_we_m;
  logic [2:0]  stat;
  logic        halted;
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;

  // Datapath / environment side.
  modport master (
    output start, instr_valid, icode, imem_error, cnd, dmem_ack, dmem_error,
    input  fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en,
           dmem_req, dmem_write, rf_we_e, rf_we_m, stat, halted,
           cycle_cnt, instr_cnt
  );

  // Controller side.
  modport slave (
    input  start, instr_valid, icode, imem_error, cnd, dmem_ack, dmem_error,
    output fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en,
           dmem_req, dmem_write, rf_we_e, rf_we_m, stat, halted,
           cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/seq_stage_ctrl_timer.sv
// Loadable up-counter with a terminal compare; used to bound how long the
// MEMORY stage waits for a data memory acknowledge.
module stage_timer #(
  parameter  int LIMIT = 16,
  localparam int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic         hit
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  // Count waiting cycles; load takes priority so each wait starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  // Asserted on the cycle whose increment makes the count reach LIMIT.
  assign hit = inc && (count == LAST);

endmodule

// File: rtl/seq_stage_ctrl.sv
// Sequential (non-pipelined) Y86 stage controller: steps one instruction at
// a time through fetch/decode/execute/memory/writeback/pc-update, raising a
// single stage enable per cycle, and parks in HALT on any fault.
module seq_stage_ctrl
  import y86_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst_n,
  seq_stage_ctrl_if.slave bus
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  state_t      state, state_nx;
  stat_t       stat_q, stat_nx;
  logic [3:0]  icode_q;
  logic        cnd_q;
  logic        retire;
  logic        timeout_hit;
  logic [31:0] cycle_cnt_q, instr_cnt_q;

  logic fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en;
  logic dmem_req, dmem_write, rf_we_e, rf_we_m;

  stage_timer #(.LIMIT(MEM_TIMEOUT)) u_mem_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == S_EXECUTE),
    .load_val ({TW{1'b0}}),
    .inc      ((state == S_MEMORY) && !bus.dmem_ack),
    .hit      (timeout_hit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state, fault status and Moore stage outputs.
  always_comb begin
    state_nx   = state;
    stat_nx    = stat_q;
    retire     = 1'b0;
    fetch_en   = 1'b0;
    decode_en  = 1'b0;
    execute_en = 1'b0;
    memory_en  = 1'b0;
    wb_en      = 1'b0;
    pc_en      = 1'b0;
    dmem_req   = 1'b0;
    dmem_write = 1'b0;
    rf_we_e    = 1'b0;
    rf_we_m    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        fetch_en = 1'b1;
        if (bus.instr_valid) begin
          if (bus.imem_error) begin
            state_nx = S_HALT;
            stat_nx  = STAT_ADR;
          end else if (bus.icode > I_POPQ) begin
            state_nx = S_HALT;
            stat_nx  = STAT_INS;
          end else if (bus.icode == I_HALT) begin
            // A halt instruction completes normally, so it retires.
            state_nx = S_HALT;
            stat_nx  = STAT_HLT;
            retire   = 1'b1;
          end else begin
            state_nx = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        decode_en = 1'b1;
        state_nx  = S_EXECUTE;
      end
      S_EXECUTE: begin
        execute_en = 1'b1;
        state_nx   = is_mem_op(icode_q) ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        memory_en  = 1'b1;
        dmem_req   = 1'b1;
        dmem_write = is_mem_write(icode_q);
        // An ack on the final allowed cycle still completes the access.
        if (bus.dmem_ack) begin
          if (bus.dmem_error) begin
            state_nx = S_HALT;
            stat_nx  = STAT_ADR;
          end else begin
            state_nx = S_WRITEBACK;
          end
        end else if (timeout_hit) begin
          state_nx = S_HALT;
          stat_nx  = STAT_ADR;
        end
      end
      S_WRITEBACK: begin
        wb_en    = 1'b1;
        rf_we_e  = writes_vale(icode_q, cnd_q);
        rf_we_m  = writes_valm(icode_q);
        state_nx = S_PCUPDATE;
      end
      S_PCUPDATE: begin
        pc_en    = 1'b1;
        retire   = 1'b1;
        state_nx = S_FETCH;
      end
      S_HALT: begin
        state_nx = S_HALT;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Latch instruction context and status for the rest of the instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icode_q <= 4'd0;
      cnd_q   <= 1'b0;
      stat_q  <= STAT_AOK;
    end else begin
      if ((state == S_FETCH) && bus.instr_valid) icode_q <= bus.icode;
      if (state == S_EXECUTE) cnd_q <= bus.cnd;
      stat_q <= stat_nx;
    end
  end

  // Activity and retirement counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= 32'd0;
      instr_cnt_q <= 32'd0;
    end else begin
      if ((state != S_IDLE) && (state != S_HALT)) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (retire) instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign bus.fetch_en   = fetch_en;
  assign bus.decode_en  = decode_en;
  assign bus.execute_en = execute_en;
  assign bus.memory_en  = memory_en;
  assign bus.wb_en      = wb_en;
  assign bus.pc_en      = pc_en;
  assign bus.dmem_req   = dmem_req;
  assign bus.dmem_write = dmem_write;
  assign bus.rf_we_e    = rf_we_e;
  assign bus.rf_we_m    = rf_we_m;
  assign bus.stat       = stat_q;
  assign bus.halted     = (state == S_HALT);
  assign bus.cycle_cnt  = cycle_cnt_q;
  assign bus.instr_cnt  = instr_cnt_q;

endmodule

// File: doc/seq_stage_ctrl.md
SEQ_STAGE_CTRL -- requirements
Module: seq_stage_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, max cycles MEMORY waits for dmem_ack before fault.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  leave IDLE and begin fetching.
REQ-005 instr_valid  input  1  fetch unit has a complete instruction; icode valid this cycle.
REQ-006 icode  input  4  opcode of fetched instruction.
REQ-007 imem_error  input  1  instruction fetch address fault, sampled with instr_valid.
REQ-008 cnd  input  1  ALU condition result, sampled in EXECUTE.
REQ-009 dmem_ack  input  1  data memory completed request.
REQ-010 dmem_error  input  1  data memory address fault, sampled with dmem_ack.
REQ-011 fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en  output  1 each  stage enables, one-hot or all zero.
REQ-012 dmem_req  output  1  data memory request, held until ack.
REQ-013 dmem_write  output  1  request is a write (icode 4, 8, 10).
REQ-014 rf_we_e  output  1  write valE to register file.
REQ-015 rf_we_m  output  1  write valM to register file.
REQ-016 stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
REQ-017 halted  output  1  controller stopped in HALT.
REQ-018 cycle_cnt  output  32  active cycles since reset.
REQ-019 instr_cnt  output  32  retired instructions since reset.

Function
REQ-020 States IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPDATE, HALT; registered state, Moore outputs.
REQ-021 IDLE->FETCH when start=1; otherwise stay.
REQ-022 FETCH holds fetch_en=1 until instr_valid=1; icode latched into internal register on that cycle.
REQ-023 On instr_valid: imem_error=1 -> stat=ADR, HALT; else icode>11 -> stat=INS, HALT; else icode=0 -> stat=HLT, HALT, instr_cnt+1; else DECODE.
REQ-024 DECODE->EXECUTE unconditionally; cnd latched on EXECUTE cycle.
REQ-025 EXECUTE->MEMORY for icode 4,5,8,9,10,11; else ->WRITEBACK.
REQ-026 MEMORY: dmem_req=1 every cycle until dmem_ack; dmem_write=1 for icode 4,8,10.
REQ-027 dmem_ack with dmem_error=1 -> stat=ADR, HALT; ack without error -> WRITEBACK.
REQ-028 Wait counter cleared on MEMORY entry, +1 per cycle without ack; reaching MEM_TIMEOUT -> stat=ADR, HALT; ack in same cycle counter reaches limit wins.
REQ-029 WRITEBACK: rf_we_e=1 for icode 3,6,8,9,10,11, and for icode 2 only if latched cnd=1; rf_we_m=1 for icode 5,11; then ->PCUPDATE.
REQ-030 PCUPDATE: pc_en=1, instr_cnt+1, ->FETCH.
REQ-031 Minimum latency per non-memory instruction 5 cycles, memory instruction 6 cycles (ack on first MEMORY cycle).
REQ-032 HALT sticky: all enables and dmem_req 0, halted=1, start ignored; only reset exits.
REQ-033 cycle_cnt increments every cycle not IDLE or HALT; both counters wrap modulo 2^32.
REQ-034 stat=AOK in all non-HALT states; fault stat set on HALT entry and held.

Reset
REQ-035 rst_n=0 immediately forces IDLE, all enables/dmem_req/dmem_write/rf_we_* 0, stat=AOK, halted=0, counters 0, latched icode/cnd 0, including mid-MEMORY (request dropped without ack).
REQ-036 Release of rst_n takes effect on next clk edge; no action before start.

Structure
REQ-037 Package y86_pkg holds icode constants (HALT..POPQ = 0..11), stat codes, and state enum.
REQ-038 Sub-module stage_timer: loadable up-counter with limit compare, used for MEMORY timeout.

Verification
REQ-039 start, icode=6 instr_valid immediate, cnd=1 -> FETCH,DECODE,EXECUTE,WRITEBACK(rf_we_e=1),PCUPDATE; instr_cnt=1, cycle_cnt=5.
REQ-040 icode=5, dmem_ack after 3 cycles -> dmem_req high 3 cycles, dmem_write=0, then rf_we_m=1, rf_we_e=0.
REQ-041 icode=2 with cnd=0 -> rf_we_e=0 in WRITEBACK; repeat with cnd=1 -> rf_we_e=1.
REQ-042 icode=4, dmem_ack never -> after 16 MEMORY cycles HALT, stat=3, halted=1, start pulse ignored.
REQ-043 icode=13 -> stat=4 HALT; separate run icode=0 -> stat=2, instr_cnt=1.
REQ-044 rst_n low during MEMORY with dmem_req=1 -> dmem_req 0 immediately, state IDLE, counters 0.
